// File: rtl/sram_ctrl.sv
// Sequencer between a single-beat 32-bit req/ack port and the asynchronous SRAM pad block.
// Writes get address setup/hold around a fixed-width sram_we pulse; reads wait RD_WAIT cycles.
module sram_ctrl #(
    parameter int unsigned ADDR_W   = 20,
    parameter int unsigned RD_WAIT  = 2,
    parameter int unsigned WR_PULSE = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        be,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              ack,
    output logic              busy,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [5:0]        sram_we,
    output logic [47:0]       sram_wdata,
    input  logic [47:0]       sram_rdata
);

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StWrSetup,
        StWrPulse,
        StWrHold
    } state_e;

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [3:0]          be_q, be_d;
    logic                ack_q, ack_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [ADDR_W-1:0]   sram_addr_q, sram_addr_d;
    logic [5:0]          sram_we_q, sram_we_d;
    logic [47:0]         sram_wdata_q, sram_wdata_d;

    // Chip 2 is unpopulated on the read side as well.
    logic unused_rdata_hi;
    assign unused_rdata_hi = ^sram_rdata[47:32];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    state_d = wr ? StWrSetup : StRd;
                end
            end
            StRd: begin
                if (cnt_q == 4'd0) begin
                    state_d = StIdle;
                end
            end
            StWrSetup: state_d = StWrPulse;
            StWrPulse: begin
                if (cnt_q == 4'd0) begin
                    state_d = StWrHold;
                end
            end
            StWrHold: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Output / datapath next-state logic; every output is registered
    always_comb begin
        cnt_d        = cnt_q;
        be_d         = be_q;
        ack_d        = 1'b0;
        rdata_d      = rdata_q;
        sram_addr_d  = sram_addr_q;
        sram_we_d    = sram_we_q;
        sram_wdata_d = sram_wdata_q;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    sram_addr_d  = addr;
                    sram_wdata_d = {16'h0000, wdata};
                    be_d         = be;
                    sram_we_d    = 6'b000000;
                    if (!wr) begin
                        cnt_d = 4'(RD_WAIT - 1);
                    end
                end
            end
            StRd: begin
                sram_we_d = 6'b000000;
                if (cnt_q == 4'd0) begin
                    rdata_d = sram_rdata[31:0];
                    ack_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StWrSetup: begin
                sram_we_d = {2'b00, be_q};
                cnt_d     = 4'(WR_PULSE - 1);
            end
            StWrPulse: begin
                if (cnt_q == 4'd0) begin
                    sram_we_d = 6'b000000;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StWrHold: begin
                sram_we_d = 6'b000000;
                ack_d     = 1'b1;
            end
            default: begin
                sram_we_d = 6'b000000;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= 4'd0;
            be_q         <= 4'd0;
            ack_q        <= 1'b0;
            rdata_q      <= 32'h0;
            sram_addr_q  <= '0;
            sram_we_q    <= 6'b000000;
            sram_wdata_q <= 48'h0;
        end else begin
            cnt_q        <= cnt_d;
            be_q         <= be_d;
            ack_q        <= ack_d;
            rdata_q      <= rdata_d;
            sram_addr_q  <= sram_addr_d;
            sram_we_q    <= sram_we_d;
            sram_wdata_q <= sram_wdata_d;
        end
    end

    assign busy       = (state_q != StIdle);
    assign ack        = ack_q;
    assign rdata      = rdata_q;
    assign sram_addr  = sram_addr_q;
    assign sram_we    = sram_we_q;
    assign sram_wdata = sram_wdata_q;

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Sequencing controller directly upstream of the board SRAM pad block (three 16-bit asynchronous SRAM chips, 48-bit data path).
- Converts single-beat 32-bit CPU-side requests (req/ack, byte enables) into timed address / byte-write-enable / data phases.
- Guarantees address setup and hold around every write pulse, and waits a fixed number of cycles before latching read data.
- Only chips 0 and 1 are used (bits 31:0); chip 2 is never written and always receives zero data.

Parameters:
- ADDR_W, 20, SRAM word address width.
- RD_WAIT, 2, cycles the read address is held before data is latched; legal range 1..15.
- WR_PULSE, 2, cycles sram_we is asserted per write; legal range 1..15.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  1  request valid; sampled only in IDLE.
- wr  in  1  1 = write, 0 = read; captured with req.
- addr  in  ADDR_W  word address; captured with req.
- be  in  4  byte enables for a write; bit i enables wdata[8i+7:8i].
- wdata  in  32  write data; captured with req.
- rdata  out  32  read data; registered and valid while ack=1, held until the next read completes.
- ack  out  1  one-cycle completion pulse.
- busy  out  1  high in every state except IDLE.
- sram_addr  out  ADDR_W  to pad block addr; registered.
- sram_we  out  6  to pad block byte write enables; registered.
- sram_wdata  out  48  to pad block wdata; registered.
- sram_rdata  in  48  from pad block rdata.

Behaviour:
- Reset (asynchronous, immediate, also mid-operation):
  - state=IDLE; counter=0.
  - ack=0, busy=0, rdata=0.
  - sram_addr=0, sram_we=0, sram_wdata=0.
  - An interrupted transfer produces no ack.
- States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD.
- IDLE, req=1: capture addr→sram_addr and wdata→sram_wdata[31:0]; set sram_wdata[47:32]=0; capture be internally.
  - wr=0 → RD, counter=RD_WAIT-1.
  - wr=1 → WR_SETUP.
  - req=0: stay in IDLE, all outputs held.
- RD: sram_we=0.
  - Counter decrements each cycle.
  - At the edge where counter=0: rdata<=sram_rdata[31:0], ack<=1, go to IDLE.
  - Latency: ack visible RD_WAIT edges after the accepting edge.
- WR_SETUP: one cycle with sram_we=0 and address/data stable.
  - Exiting edge loads sram_we={2'b00, be} and counter=WR_PULSE-1.
- WR_PULSE: sram_we={2'b00,be} for exactly WR_PULSE cycles.
  - Exiting edge clears sram_we to 0.
- WR_HOLD: one cycle with sram_we=0 and address/data unchanged.
  - Exiting edge sets ack<=1 and returns to IDLE.
  - Write latency: WR_PULSE+2 edges from acceptance to ack.
- be=4'b0000 write: same state sequence and latency; sram_we stays 0 throughout.
- sram_we[5:4] is always 0.
- sram_addr and sram_wdata change only at the accepting edge, never while sram_we≠0 or in the cycle after it deasserts.
- ack is high for exactly one cycle, in which the state is IDLE.
  - If req=1 in the ack cycle, it is accepted as a new back-to-back request.
  - The requester must drop req in the ack cycle unless it issues another request.
- req while busy=1 is ignored; the requester holds req/fields until acceptance (acceptance = IDLE with req=1).
- rdata is unchanged by writes.

Test Plan:
- Reset: assert rst_n=0 mid-WR_PULSE with be=4'hF → sram_we drops to 0 asynchronously; ack=0; busy=0; no ack after release.
- Read: model returns 48'h0000_DEAD_BEEF at addr 20'h00123; issue read with RD_WAIT=2 → sram_we=0 throughout; ack exactly 2 edges after acceptance; rdata=32'hDEADBEEF.
- Write: addr 20'h0ABCD, wdata 32'h12345678, be=4'hF, WR_PULSE=2 → sram_we=6'b001111 for exactly 2 cycles, preceded and followed by one cycle of 0 with addr stable; sram_wdata=48'h0000_1234_5678; ack 4 edges after acceptance.
- Byte write: be=4'b0100 → sram_we=6'b000100; a subsequent read of the same address in the model shows only byte 2 changed.
- be=0 write → sram_we never asserted; ack after 4 edges.
- Back-to-back: hold req=1 through an ack with a read queued after a write → second request accepted in the ack cycle; busy low only in that cycle; both acks are single-cycle pulses.
